// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: valid/ready byte intake and 8-bit serial frame generator (start, data LSB first, optional parity, stop)
module uart_tx_sequencer #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end  = cnt_q == CNT_MAX;
    assign tx       = tx_q;
    assign tx_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign tx_done  = done_q;

    // tx_d is the line level for the state being entered, so tx stays a clean flop output
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ PARITY_ODD;
                    tx_d    = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_end) begin
                shift_d = {1'b1, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = PARITY_EN ? PARITY : STOP;
                    tx_d    = PARITY_EN ? par_q : 1'b1;
                end else begin
                    tx_d = shift_q[1];
                end
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (bit_end) begin
                state_d = IDLE;
                tx_d    = 1'b1;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= 8'hFF;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: three sequencers (no parity, even, odd) sharing stimulus, checked per cycle against a frame model
module tb_uart_tx_sequencer;
    localparam int C = 4;

    logic       clk, reset, tx_valid;
    logic [7:0] tx_data;
    logic [2:0] rdy_w, tx_w, busy_w, done_w;

    for (genvar g = 0; g < 3; g++) begin : d
        uart_tx_sequencer #(.CLKS_PER_BIT(C), .PARITY_EN(g > 0), .PARITY_ODD(g == 2)) u (
            .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
            .tx_ready(rdy_w[g]), .tx(tx_w[g]), .busy(busy_w[g]), .tx_done(done_w[g])
        );
    end

    typedef struct {int i; logic [7:0] d; int n;} exp_t;
    exp_t q[$];
    int   vectors = 0, miscompares = 0, cyc = 0;
    int   hs_cnt[3] = '{0, 0, 0};
    int   hs_last[3] = '{0, 0, 0};
    int   hs_prev[3] = '{0, 0, 0};
    logic rst_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s[%0d] cycle %0d: got %0d expected %0d", nm, i, cyc, act, exp);
        end
    endtask

    // Line level k bit-times into a frame carrying byte d
    function automatic logic fbit(input logic [7:0] d, input int p, input int odd, input int k);
        logic [7:0] t;
        t = d;
        if (k == 0) return 1'b0;
        if (k <= 8) return t[k-1];
        if (p != 0 && k == 9) return 1'(($countones(t) + odd) % 2);
        return 1'b1;
    endfunction

    function automatic int head(input int i);
        for (int j = 0; j < q.size(); j++) if (q[j].i == i) return j;
        return -1;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int   nb, h;
            logic e;
            nb = 10 + (i > 0 ? 1 : 0);
            chk("busy_vs_ready", i, int'(busy_w[i]), int'(!rdy_w[i]));
            if (!rst_seen) begin
                for (int j = q.size() - 1; j >= 0; j--) if (q[j].i == i) q.delete(j);
                chk("rst_tx", i, int'(tx_w[i]), 1);
                chk("rst_ready", i, int'(rdy_w[i]), 1);
                chk("rst_done", i, int'(done_w[i]), 0);
            end else begin
                h = head(i);
                e = 1'b1;
                if (h >= 0 && cyc >= q[h].n && cyc < q[h].n + nb * C)
                    e = fbit(q[h].d, nb - 10, i == 2 ? 1 : 0, (cyc - q[h].n) / C);
                chk("tx", i, int'(tx_w[i]), int'(e));
                if (done_w[i]) begin
                    chk("done_expected", i, int'(h >= 0), 1);
                    if (h >= 0) begin
                        chk("frame_len", i, cyc - q[h].n, nb * C);
                        q.delete(h);
                    end
                end else if (h >= 0 && cyc > q[h].n + nb * C) begin
                    chk("done_missing", i, 0, 1);
                    q.delete(h);
                end
            end
            if (reset && tx_valid && rdy_w[i]) begin
                q.push_back('{i: i, d: tx_data, n: cyc + 1});
                hs_prev[i] = hs_last[i];
                hs_last[i] = cyc + 1;
                hs_cnt[i]++;
            end
        end
        rst_seen = reset;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (rdy_w != 3'b111 && t < 300) begin
            tick();
            t++;
        end
        chk("idle_reached", 0, int'(rdy_w), 7);
    endtask

    task automatic send(input logic [7:0] b);
        wait_idle();
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
    endtask

    initial begin
        int base[3];
        int t;
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'($urandom);
        repeat (3) tick();
        tx_valid = 1'b0;
        reset    = 1'b1;
        tick();
        chk("no_frame_after_reset", 0, hs_cnt[0] + hs_cnt[1] + hs_cnt[2], 0);

        send(8'hA5);
        send(8'h07);

        // Back-to-back with valid held: 0x00 then 0xFF
        wait_idle();
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        base     = hs_cnt;
        tick();
        tx_data  = 8'hFF;
        t = 0;
        while (!(hs_cnt[0] >= base[0] + 2 && hs_cnt[1] >= base[1] + 2 && hs_cnt[2] >= base[2] + 2) && t < 200) begin
            tick();
            t++;
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++)
            chk("b2b_gap", i, hs_last[i] - hs_prev[i] - (9 + (i > 0 ? 1 : 0)) * C, C + 1);

        // Inputs churn during the frame; only the first byte may be taken
        wait_idle();
        base     = hs_cnt;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick();
        t = 0;
        while (rdy_w == 3'b000 && t < 100) begin
            tx_valid = ~tx_valid;
            tx_data  = 8'($urandom);
            tick();
            t++;
        end
        tx_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 3; i++) chk("one_handshake", i, hs_cnt[i] - base[i], 1);

        // Reset lands during data bit 3
        send(8'($urandom));
        repeat (16) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        send(8'h55);

        for (int k = 0; k < 1500; k++) begin
            tx_valid = ($urandom % 3) == 0;
            tx_data  = 8'($urandom);
            reset    = ($urandom % 400) != 0;
            tick();
        end
        tx_valid = 1'b0;
        reset    = 1'b1;
        wait_idle();
        repeat (5) tick();
        chk("pending_frames", 0, q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Transmit-side controller for the UART. Accepts one byte per valid/ready handshake, captures it and sequences the serial frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. Bit timing comes from an internal baud counter. The block sits between the host-side byte source and the `tx` pin, and owns all frame timing.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: `clk` cycles per serial bit (50 MHz / 115200). Legal range ≥ 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `tx_valid`  in  1  requester has a byte on `tx_data`.
- `tx_data`  in  8  byte to send; sampled only on handshake.
- `tx_ready`  out  1  sequencer can accept a byte. High only in IDLE.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  frame in progress (any state other than IDLE).
- `tx_done`  out  1  one-cycle pulse after a frame's stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: a byte is accepted on a rising edge where `tx_valid`=1 and `tx_ready`=1. `tx_data` is captured into an internal 8-bit shift register. The parity bit is computed from that same captured value.
- IDLE → START on handshake. `tx_valid` is ignored in every other state, and `tx_data` changes during a frame have no effect.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then → DATA.
- DATA: `tx` = shift[0]. Shift right once per bit. The bit index counts 0..7.
  - After bit 7 completes: → PARITY if `PARITY_EN`=1, else → STOP.
- PARITY: `tx` = XOR of the 8 captured bits, inverted when `PARITY_ODD`=1. Lasts `CLKS_PER_BIT` cycles, then → STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then → IDLE. `tx_done`=1 in the first IDLE cycle.
- Baud counter:
  - Width is ceil(log2(`CLKS_PER_BIT`)).
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
  - Cleared on handshake and on reset.
- Reset values (from the first edge with `reset`=0):
  - `tx`=1, `tx_ready`=1, `busy`=0, `tx_done`=0.
  - State IDLE; baud counter and bit index 0; shift register 8'hFF.
- Reset mid-frame: the frame is abandoned. `tx` returns to 1 on that edge and no `tx_done` is issued.
- Reset has priority over a simultaneous handshake: the byte is dropped.

## Timing
- Handshake at edge N: `tx` falls after edge N. The start bit covers cycles N+1..N+`CLKS_PER_BIT`.
- Frame length: (10 + `PARITY_EN`) × `CLKS_PER_BIT` cycles from edge N to the IDLE entry.
- `tx_done` and `tx_ready` both rise in the same cycle, at the IDLE entry.
- Back-to-back transfer: with `tx_valid` held high, the next handshake occurs at the IDLE-entry edge. The effective stop bit is then `CLKS_PER_BIT`+1 cycles, and there is one idle cycle between frames.
- `busy` = not `tx_ready`, exactly.
- All outputs are glitch-free (`tx` registered; the others are decoded from the state register).

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `tx_valid`=1 → `tx`=1, `tx_ready`=1, `busy`=0, `tx_done`=0 throughout, and no frame starts.
- Single byte 0xA5, `CLKS_PER_BIT`=4, no parity → `tx` carries 0,1,0,1,0,0,1,0,1,1, each for 4 cycles. `tx_done` pulses once, 40 cycles after the handshake.
- Parity:
  - `PARITY_EN`=1, `PARITY_ODD`=0, byte 0x07 → parity bit 1, frame 44 cycles.
  - Same byte with `PARITY_ODD`=1 → parity bit 0.
- Back-to-back 0x00 then 0xFF with `tx_valid` held → second start bit begins exactly `CLKS_PER_BIT`+1 cycles after the first stop bit starts. Both bytes are received correctly by the bench UART model.
- Data changes mid-frame: send 0x3C, then toggle `tx_data` and `tx_valid` every cycle during the frame → serial output is still 0x3C, and exactly one handshake occurs.
- Reset during DATA bit 3 → `tx`=1 on the next edge, no `tx_done`. After release, the sequencer accepts 0x55 and transmits it correctly.
